// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: clock frequency, FSM state numbering, parity helper.
package uart_tx_pkg;

    // UART reference clock; 16x oversampling of 115200 baud.
    localparam int UART_CLK_FREQ = 1_843_200;

    // Numbering is shared with the receive path.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: tick_o marks the last clk cycle of each bit period.
module uart_baud_gen #(
    parameter int BAUD_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_CNT - 1);

    logic [CW-1:0] cnt;

    assign tick_o = en_i && (cnt == LAST);

    // Count 0..BAUD_CNT-1 while enabled; hold at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop serialiser.
//
// state  | meaning
// IDLE   | line high, waiting for a held byte
// START  | driving the start bit (low)
// DATA   | shifting out 8 data bits, LSB first
// PARITY | driving the parity bit (only when PARITY_EN)
// STOP   | driving 1 or 2 stop bits (high); may launch the next byte directly
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_en_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    localparam int   BAUD_CNT  = UART_CLK_FREQ / BAUD_RATE;
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e state;
    logic [7:0]  hold_reg;
    logic        hold_valid;
    logic [7:0]  shift_reg;
    logic [7:0]  frame_byte;
    logic [2:0]  bit_idx;
    logic        stop_cnt;
    logic        bit_end;
    logic        baud_en;

    assign tx_ready_o = cfg_en_i & ~hold_valid;
    assign tx_busy_o  = (state != IDLE) | hold_valid;

    // Gating with cfg_en_i clears the bit timer on the same edge the frame is abandoned.
    assign baud_en = (state != IDLE) && cfg_en_i;

    uart_baud_gen #(
        .BAUD_CNT (BAUD_CNT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (baud_en),
        .tick_o (bit_end)
    );

    // Handshake capture and frame sequencing; disable behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || !cfg_en_i) begin
            state      <= IDLE;
            tx_o       <= 1'b1;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            frame_byte <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            // ready is low while hold_valid is set, so this never collides with a launch
            if (tx_valid_i && tx_ready_o) begin
                hold_reg   <= tx_data_i;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        shift_reg  <= hold_reg;
                        frame_byte <= hold_reg;
                        hold_valid <= 1'b0;
                        tx_o       <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        tx_o    <= shift_reg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx != 3'd7) begin
                            shift_reg <= shift_reg >> 1;
                            tx_o      <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end else if (PARITY_EN != 0) begin
                            tx_o  <= parity_bit(frame_byte, PARITY_ODD != 0);
                            state <= PARITY;
                        end else begin
                            tx_o     <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        tx_o     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt != STOP_LAST) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else if (hold_valid) begin
                            // back-to-back frame: no idle cycle between stop and start
                            shift_reg  <= hold_reg;
                            frame_byte <= hold_reg;
                            hold_valid <= 1'b0;
                            tx_o       <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations, scoreboard of sent bytes, line-level frame monitor.
module tb_uart_tx;

    localparam int BAUD = 16;
    localparam int ND   = 4;

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;

    // dut: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8E2
    int cfg_pe [ND] = '{0, 1, 1, 1};
    int cfg_po [ND] = '{0, 0, 1, 0};
    int cfg_sb [ND] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst      [ND];
    logic       cfg_en   [ND];
    logic [7:0] tx_data  [ND];
    logic       tx_valid [ND];
    logic       tx_ready [ND];
    logic       tx_line  [ND];
    logic       tx_busy  [ND];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   start_cnt  [ND] = '{0, 0, 0, 0};
    int   last_start [ND] = '{0, 0, 0, 0};
    int   prev_start [ND] = '{0, 0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .cfg_en_i(cfg_en[0]), .tx_data_i(tx_data[0]),
        .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .tx_o(tx_line[0]), .tx_busy_o(tx_busy[0]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .cfg_en_i(cfg_en[1]), .tx_data_i(tx_data[1]),
        .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .tx_o(tx_line[1]), .tx_busy_o(tx_busy[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .cfg_en_i(cfg_en[2]), .tx_data_i(tx_data[2]),
        .tx_valid_i(tx_valid[2]), .tx_ready_o(tx_ready[2]), .tx_o(tx_line[2]), .tx_busy_o(tx_busy[2]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst[3]), .cfg_en_i(cfg_en[3]), .tx_data_i(tx_data[3]),
        .tx_valid_i(tx_valid[3]), .tx_ready_o(tx_ready[3]), .tx_o(tx_line[3]), .tx_busy_o(tx_busy[3]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int find_exp(input int d);
        foreach (sb[i]) if (sb[i].d == d) return i;
        return -1;
    endfunction

    function automatic void drop_exp(input int d);
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
    endfunction

    function automatic int frame_len(input int d);
        return (1 + 8 + cfg_pe[d] + cfg_sb[d]) * BAUD;
    endfunction

    // Decodes frames off the line and compares every sample with the ideal waveform.
    task automatic monitor(input int d);
        logic [7:0] b;
        logic       ebits [12];
        int         nb, idx, ev, ov;
        bit         ok, aborted;
        forever begin
            do @(negedge clk); while (!(cfg_en[d] && !rst[d] && tx_line[d] == 1'b0));
            prev_start[d] = last_start[d];
            last_start[d] = cyc;
            start_cnt[d]++;
            idx = find_exp(d);
            b = 8'h00;
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected frame dut%0d at cycle %0d: got start bit, required idle line", d, cyc);
            end else begin
                b = sb[idx].b;
                sb.delete(idx);
            end
            ebits[0] = 1'b0;
            for (int i = 0; i < 8; i++) ebits[1 + i] = b[i];
            nb = 9;
            if (cfg_pe[d] != 0) begin
                ebits[nb] = (^b) ^ (cfg_po[d] != 0);
                nb++;
            end
            for (int s = 0; s < cfg_sb[d]; s++) begin
                ebits[nb] = 1'b1;
                nb++;
            end
            ok = 1'b1;
            aborted = 1'b0;
            ev = 0;
            ov = 0;
            for (int k = 0; k < nb * BAUD; k++) begin
                if (k > 0) @(negedge clk);
                if (!cfg_en[d] || rst[d]) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx_line[d] !== ebits[k / BAUD]) ok = 1'b0;
                if (k % BAUD == BAUD / 2) begin
                    ov = ov | (int'(tx_line[d]) << (k / BAUD));
                    ev = ev | (int'(ebits[k / BAUD]) << (k / BAUD));
                end
            end
            if (!aborted && idx >= 0) begin
                // a glitch within a bit makes the sampled pattern differ from the ideal one
                if (!ok && ov == ev) ov = ov ^ 32'h8000_0000;
                check($sformatf("frame dut%0d byte %02h (bit pattern, LSB = start)", d, b), ov, ev);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    // Offers a byte until accepted; returns the accepting edge number (or -1 on timeout).
    task automatic send(input int d, input logic [7:0] b, input bit keep_valid, output int acc);
        int n = 0;
        tx_data[d]  = b;
        tx_valid[d] = 1'b1;
        acc = -1;
        forever begin
            @(negedge clk);
            if (tx_ready[d]) break;
            n++;
            if (n > 3000) begin
                check($sformatf("accept timeout dut%0d", d), 0, 1);
                tx_valid[d] = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        sb.push_back('{d: d, b: b});
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep_valid) tx_valid[d] = 1'b0;
    endtask

    task automatic wait_starts(input int d, input int target, output int s);
        int n = 0;
        while (start_cnt[d] < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (start_cnt[d] < target) begin
            check($sformatf("start timeout dut%0d", d), start_cnt[d], target);
            s = -1;
        end else begin
            s = last_start[d];
        end
    endtask

    task automatic wait_busy_low(input int d, output int fall);
        int n = 0;
        @(negedge clk);
        while (tx_busy[d] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy[d]) check($sformatf("busy timeout dut%0d", d), 1, 0);
        fall = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single byte: start latency after accept, and busy falling after the last stop bit.
    task automatic single_frame(input int d, input logic [7:0] b);
        int c0, acc, s, fall;
        c0 = start_cnt[d];
        send(d, b, 1'b0, acc);
        wait_starts(d, c0 + 1, s);
        check($sformatf("start latency dut%0d", d), s - acc, 1);
        wait_busy_low(d, fall);
        check($sformatf("frame length dut%0d", d), fall - s, frame_len(d));
    endtask

    initial begin
        int a1, a2, a3, a4, s, fall, c0, gap;
        bit keep;

        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1;
            cfg_en[d] = 1'b0;
            tx_data[d] = 8'h00;
            tx_valid[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset tx_o dut%0d", d), int'(tx_line[d]), 1);
            check($sformatf("reset busy dut%0d", d), int'(tx_busy[d]), 0);
            check($sformatf("reset ready disabled dut%0d", d), int'(tx_ready[d]), 0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) cfg_en[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) check($sformatf("ready enabled dut%0d", d), int'(tx_ready[d]), 1);
        @(posedge clk);
        #1;

        // 8N1 0xA5
        single_frame(0, 8'hA5);

        // parity even and odd on 0x07
        single_frame(1, 8'h07);
        single_frame(2, 8'h07);

        // two stop bits, back-to-back with valid held
        c0 = start_cnt[3];
        send(3, 8'h00, 1'b1, a1);
        send(3, 8'hFF, 1'b0, a2);
        check("second accept follows first launch", a2 - a1, 2);
        @(negedge clk);
        check("ready low while holding", int'(tx_ready[3]), 0);
        wait_starts(3, c0 + 2, s);
        check("contiguous frames 8E2", last_start[3] - prev_start[3], frame_len(3));
        check("ready after second launch", int'(tx_ready[3]), 1);
        wait_busy_low(3, fall);
        check("frame length second 8E2", fall - s, frame_len(3));

        // four queued bytes with valid held throughout
        send(0, 8'h11, 1'b1, a1);
        send(0, 8'h22, 1'b1, a2);
        send(0, 8'h33, 1'b1, a3);
        send(0, 8'h44, 1'b0, a4);
        check("queued accept 2", a2 - a1, 2);
        check("queued accept 3", a3 - a2, frame_len(0));
        check("queued accept 4", a4 - a3, frame_len(0));
        wait_busy_low(0, fall);

        // disable during data bit 3 with a byte pending
        c0 = start_cnt[0];
        send(0, 8'h3C, 1'b1, a1);
        send(0, 8'h99, 1'b0, a2);
        wait_starts(0, c0 + 1, s);
        wait_cyc(s + 4 * BAUD + 5);
        cfg_en[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("disable tx_o high", int'(tx_line[0]), 1);
        check("disable busy low", int'(tx_busy[0]), 0);
        check("disable ready low", int'(tx_ready[0]), 0);
        drop_exp(0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        cfg_en[0] = 1'b1;
        c0 = start_cnt[0];
        repeat (20) @(negedge clk);
        check("pending byte discarded", start_cnt[0] - c0, 0);
        check("idle after re-enable", int'(tx_busy[0]), 0);
        @(posedge clk);
        #1;
        single_frame(0, 8'h55);

        // reset during the parity bit
        c0 = start_cnt[1];
        send(1, 8'h0F, 1'b0, a1);
        wait_starts(1, c0 + 1, s);
        wait_cyc(s + 9 * BAUD + 6);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("rst tx_o high", int'(tx_line[1]), 1);
        check("rst busy low", int'(tx_busy[1]), 0);
        check("rst ready = cfg_en", int'(tx_ready[1]), 1);
        drop_exp(1);
        @(posedge clk);
        #1;

        // random traffic on every configuration
        for (int d = 0; d < ND; d++) begin
            keep = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (!keep) begin
                    gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 250);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
                keep = (i < 5) && ($urandom_range(0, 1) == 1);
                send(d, 8'($urandom), keep, a1);
            end
            wait_busy_low(d, fall);
        end

        begin
            int n = 0;
            while ((sb.size() != 0 || tx_busy[0] || tx_busy[1] || tx_busy[2] || tx_busy[3]) && n < 5000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (4) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter for the GreenRio2 peripheral subsystem. It is the transmit counterpart of the existing UART receive path.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises each byte as: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Driven from the same UART clock and `UART_CLK_FREQ` config as the receiver.

Parameters:
- BAUD_RATE, 115200, line rate; bit period BAUD_CNT = `UART_CLK_FREQ/BAUD_RATE` clk cycles, exact.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity (bit = XOR of data), 1 = odd (bit = ~XOR of data).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_en_i  in  1  transmitter enable.
- tx_data_i  in  8  byte to send.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  holding register free; = cfg_en_i & ~hold_valid (combinational).
- tx_o  out  1  serial line, registered, idle high.
- tx_busy_o  out  1  high when FSM is not IDLE or hold_valid is set.

Behaviour:
- Reset values:
  - tx_o = 1, FSM = IDLE, hold_valid = 0, baud counter = 0, bit index = 0.
  - Hence tx_busy_o = 0 and tx_ready_o = cfg_en_i.
- Handshake:
  - A byte transfers on any edge where tx_valid_i & tx_ready_o; hold_reg <= tx_data_i, hold_valid <= 1.
  - tx_valid_i without tx_ready_o is ignored; the source holds data until ready.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Baud counter:
  - Runs only outside IDLE; counts 0..BAUD_CNT-1.
  - bit_end = (cnt == BAUD_CNT-1); counter wraps to 0 on bit_end.
  - Counter width = $clog2(BAUD_CNT).
- IDLE:
  - If hold_valid: shift_reg <= hold_reg, hold_valid <= 0, tx_o <= 0, go to START, cnt <= 0.
  - Latency: byte accepted at edge E -> tx_o low from edge E+1.
- START:
  - tx_o = 0 for BAUD_CNT cycles.
  - On bit_end: tx_o <= shift_reg[0], go to DATA, bit index = 0.
- DATA:
  - Each bit is held BAUD_CNT cycles.
  - On bit_end with index < 7: shift right, tx_o <= next bit, index++.
  - On bit_end with index == 7:
    - PARITY_EN = 1: go to PARITY; tx_o <= parity computed from the launched byte.
    - PARITY_EN = 0: go to STOP; tx_o <= 1.
- PARITY: one bit period, then go to STOP with tx_o <= 1.
- STOP:
  - tx_o = 1 for STOP_BITS*BAUD_CNT cycles; a stop-bit counter handles STOP_BITS = 2.
  - At the end of the last stop bit:
    - If hold_valid: launch the next byte directly (tx_o <= 0, START). No extra idle cycle, so back-to-back frames are contiguous.
    - Else: go to IDLE.
- Holding register:
  - Free again the cycle after launch, so a second byte can be accepted while the first is shifting.
  - An accept on the same edge as a launch is impossible, because ready is low while hold_valid = 1.
- cfg_en_i = 0, at any time including mid-frame:
  - Next edge: FSM -> IDLE, tx_o <= 1, hold_valid <= 0, counters cleared.
  - A partial frame is abandoned; tx_ready_o = 0 while disabled.
- rst mid-frame: same effect as reset; tx_o is high on the following cycle.
- tx_data_i changes after the handshake do not affect the frame in flight.

Decomposition:
- perips_cfg.vh (shared):
  - `UART_CLK_FREQ`.
  - UART state encodings IDLE/START/DATA/PARITY/STOP as localparams, so uart_tx and the receiver share numbering.
- Sub-module uart_baud_gen:
  - Parameter BAUD_CNT; ports clk, rst, en_i, tick_o.
  - tick_o is asserted on the last cycle of each bit period while en_i is high; the counter clears while en_i is low.
  - Reusable by the receiver later.

Test Plan (bench sets BAUD_CNT = 16 via `UART_CLK_FREQ`/BAUD_RATE):
1. Reset, cfg_en_i = 1, send 0xA5, PARITY_EN = 0, STOP_BITS = 1 -> tx_o low one cycle after accept; then bits 1,0,1,0,0,1,0,1 at 16 cycles each; 16-cycle stop; frame = 160 cycles; tx_busy_o falls after the stop bit.
2. PARITY_EN = 1, PARITY_ODD = 0, send 0x07 -> parity bit 1 after the data; PARITY_ODD = 1, send 0x07 -> parity bit 0; frame = 176 cycles.
3. STOP_BITS = 2, send 0x00 then 0xFF with tx_valid_i held high -> second accepted right after the first launch; tx_ready_o low until the second launch; 32-cycle stop then an immediate start bit, no gap.
4. Hold tx_valid_i while hold_valid = 1 -> no overwrite; the byte transfers only when tx_ready_o returns high; no byte lost or duplicated across 4 queued bytes.
5. Drop cfg_en_i during data bit 3 -> tx_o = 1 next cycle; FSM IDLE; tx_ready_o = 0; the pending byte is discarded; re-enable and send 0x55 -> a clean full frame.
6. Assert rst during the parity bit -> tx_o = 1, tx_busy_o = 0, tx_ready_o = cfg_en_i on the next cycle.
